// File: rtl/lcd_pkg.sv
// Shared constants and types for the multi-row HD44780 streamer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam logic [7:0] SPACE     = 8'h20;

  // FRAME_END is zero-length: it is folded into the last CHAR wrap and never held.
  typedef enum logic [1:0] {S_INIT, S_ADDR, S_CHAR, S_FRAME_END} state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  function automatic logic [7:0] row_offset(input logic [1:0] row);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Per-transaction cycle counter: EN strobe window and the stretched clear-display wait.
module lcd_bus_timer #(
  parameter int CYC_LEN  = 2000,
  parameter int EN_START = 200,
  parameter int EN_END   = 1800,
  parameter int CLR_WAIT = 4000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic long_wait_i,
  output logic lcd_en_o,
  output logic done_o
);

  localparam int CW = $clog2(CYC_LEN + CLR_WAIT + 1);
  localparam logic [CW-1:0] LIM_S = CW'(CYC_LEN);
  localparam logic [CW-1:0] LIM_L = CW'(CYC_LEN + CLR_WAIT);
  localparam logic [CW-1:0] EN_LO = CW'(EN_START);
  localparam logic [CW-1:0] EN_HI = CW'(EN_END);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_q, long_d;
  logic          en_q, en_d;
  logic          active, long_cur;
  logic [CW-1:0] limit;

  // Idle only at cnt==0 without a start; otherwise transactions run back to back.
  assign active   = (cnt_q != '0) || start_i;
  assign long_cur = (cnt_q == '0) ? long_wait_i : long_q;
  assign limit    = long_cur ? LIM_L : LIM_S;
  assign done_o   = active && (cnt_q == limit);
  assign lcd_en_o = en_q;

  always_comb begin
    cnt_d  = cnt_q;
    long_d = long_q;
    en_d   = (cnt_q > EN_LO) && (cnt_q <= EN_HI);
    if (cnt_q == '0 && start_i) long_d = long_wait_i;
    if (active) cnt_d = done_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      long_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      long_q <= long_d;
      en_q   <= en_d;
    end
  end

endmodule

// File: rtl/text_lcd_mr.sv
// ROWS x COLS character-LCD streamer: power-on init, then continuous refresh from a
// double-buffered shadow frame that only changes at frame boundaries.
module text_lcd_mr
  import lcd_pkg::*;
#(
  parameter int COLS     = 16,
  parameter int ROWS     = 2,
  parameter int CYC_LEN  = 2000,
  parameter int EN_START = 200,
  parameter int EN_END   = 1800,
  parameter int CLR_WAIT = 4000
) (
  input  logic                   LCDCLK,
  input  logic                   PRESETn,
  input  logic [ROWS*COLS*8-1:0] data,
  input  logic                   load,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic                   LCD_EN,
  output logic [7:0]             LCD_DATA
);

  localparam int NCH = ROWS * COLS;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);
  localparam logic [5:0] COL_LAST = 6'(COLS - 1);

  state_e                  state_q, state_d;
  logic [1:0]              step_q, step_d;
  logic [1:0]              row_q, row_d;
  logic [5:0]              col_q, col_d;
  logic [NCH-1:0][7:0]     shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    issue_q;
  lcd_word_t               word_q, word_nxt;
  logic                    done, long_wait, boundary;
  logic [IW-1:0]           sel;

  lcd_bus_timer #(
    .CYC_LEN (CYC_LEN),
    .EN_START(EN_START),
    .EN_END  (EN_END),
    .CLR_WAIT(CLR_WAIT)
  ) u_timer (
    .clk_i      (LCDCLK),
    .rst_ni     (PRESETn),
    .start_i    (issue_q),
    .long_wait_i(long_wait),
    .lcd_en_o   (LCD_EN),
    .done_o     (done)
  );

  assign long_wait = (state_q == S_INIT) && (step_q == 2'd3);
  assign busy      = (state_q == S_INIT) || pending_q;
  assign LCD_RW    = 1'b0;
  assign LCD_RS    = word_q.rs;
  assign LCD_DATA  = word_q.data;

  // Byte k lives at packed index NCH-1-k, so row 0 col 0 is the MSB byte of data.
  always_comb sel = IW'(NCH - 1 - (int'(row_q) * COLS + int'(col_q)));

  always_comb begin
    word_nxt = '{rs: 1'b0, data: init_cmd(step_q)};
    case (state_q)
      S_ADDR:  word_nxt = '{rs: 1'b0, data: SET_DDRAM | row_offset(row_q)};
      S_CHAR:  word_nxt = '{rs: 1'b1, data: shadow_q[sel]};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    row_d      = row_q;
    col_d      = col_q;
    boundary   = 1'b0;
    frame_done = 1'b0;
    if (done) begin
      case (state_q)
        S_INIT: begin
          if (step_q == 2'd3) begin
            state_d  = S_ADDR;
            row_d    = '0;
            col_d    = '0;
            boundary = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        S_ADDR: begin
          state_d = S_CHAR;
          col_d   = '0;
        end
        S_CHAR: begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_ADDR;
            if (row_q == ROW_LAST) begin
              row_d      = '0;
              frame_done = 1'b1;
              boundary   = 1'b1;
            end else begin
              row_d = row_q + 2'd1;
            end
          end else begin
            col_d = col_q + 6'd1;
          end
        end
        default: state_d = S_ADDR;
      endcase
    end
  end

  // A load landing on the boundary cycle is folded in directly and never shows as pending.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q | load;
    if (boundary && pending_d) begin
      shadow_d  = data;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_INIT;
      step_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      shadow_q  <= {NCH{SPACE}};
      pending_q <= 1'b0;
      issue_q   <= 1'b1;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      row_q     <= row_d;
      col_q     <= col_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      issue_q   <= done;
      if (issue_q) word_q <= word_nxt;
    end
  end

endmodule
